// File: rtl/matrix_op_sequencer.sv
// Stream adapter and initiator for one 4x4 matrix engine: loads A and B from a byte
// stream, starts the engine, waits for a guarded completion and drains results row-major.
module matrix_op_sequencer #(
    parameter int N            = 4,
    parameter int DATA_W       = 8,
    parameter int RES_W        = 16,
    parameter int GUARD_CYCLES = 24,
    parameter int TIMEOUT      = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] mtx_a [0:N-1][0:N-1],
    output logic [DATA_W-1:0] mtx_b [0:N-1][0:N-1],
    output logic              mtx_start,
    input  logic [RES_W-1:0]  mtx_c [0:N-1][0:N-1],
    input  logic              mtx_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              timeout_err
);

    localparam int NN    = N * N;
    localparam int IDX_W = $clog2(NN);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    typedef enum logic [2:0] {
        ST_LOAD_A = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   k_r, k_s, m_r, m_s;
    logic [CNT_W-1:0]   wait_cnt_r, wait_cnt_s, cnt_inc_s;
    logic               a_we_s, b_we_s, cap_s, timeout_s;
    logic               load_hs_s, out_hs_s;
    logic [DATA_W-1:0]  a_r   [0:N-1][0:N-1];
    logic [DATA_W-1:0]  b_r   [0:N-1][0:N-1];
    logic [RES_W-1:0]   res_r [0:N-1][0:N-1];
    logic [RES_W-1:0]   out_data_s;
    logic               in_ready_r, mtx_start_r, out_valid_r, out_last_r, busy_r, timeout_err_r;

    assign load_hs_s = in_valid && in_ready_r;
    assign out_hs_s  = out_valid_r && out_ready;
    // The wait count is "cycles since the start cycle", so the guard and timeout compare the incremented value.
    assign cnt_inc_s = wait_cnt_r + CNT_W'(1);

    // Next-state, index and strobe decode.
    always_comb begin
        state_s    = state_r;
        k_s        = k_r;
        m_s        = m_r;
        wait_cnt_s = wait_cnt_r;
        a_we_s     = 1'b0;
        b_we_s     = 1'b0;
        cap_s      = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_LOAD_A, ST_LOAD_B: begin
                if (load_hs_s) begin
                    a_we_s = (state_r == ST_LOAD_A);
                    b_we_s = (state_r == ST_LOAD_B);
                    if (k_r == LAST_IDX) begin
                        k_s     = '0;
                        state_s = (state_r == ST_LOAD_A) ? ST_LOAD_B : ST_START;
                    end else begin
                        k_s = k_r + IDX_W'(1);
                    end
                end else begin
                    k_s = k_r;
                end
            end
            ST_START: begin
                wait_cnt_s = '0;
                state_s    = ST_WAIT;
            end
            ST_WAIT: begin
                wait_cnt_s = cnt_inc_s;
                if ((cnt_inc_s >= CNT_W'(GUARD_CYCLES)) && mtx_done) begin
                    cap_s   = 1'b1;
                    state_s = ST_DRAIN;
                end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
                    timeout_s = 1'b1;
                    state_s   = ST_LOAD_A;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (out_hs_s) begin
                    if (m_r == LAST_IDX) begin
                        m_s     = '0;
                        state_s = ST_LOAD_A;
                    end else begin
                        m_s = m_r + IDX_W'(1);
                    end
                end else begin
                    m_s = m_r;
                end
            end
            default: begin
                state_s = ST_LOAD_A;
            end
        endcase
    end

    // State, counters and output flags; flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_LOAD_A;
            k_r           <= '0;
            m_r           <= '0;
            wait_cnt_r    <= '0;
            in_ready_r    <= 1'b1;
            mtx_start_r   <= 1'b0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            k_r           <= k_s;
            m_r           <= m_s;
            wait_cnt_r    <= wait_cnt_s;
            in_ready_r    <= (state_s == ST_LOAD_A) || (state_s == ST_LOAD_B);
            mtx_start_r   <= (state_s == ST_START);
            out_valid_r   <= (state_s == ST_DRAIN);
            out_last_r    <= (state_s == ST_DRAIN) && (m_s == LAST_IDX);
            busy_r        <= (state_s == ST_START) || (state_s == ST_WAIT) || (state_s == ST_DRAIN);
            timeout_err_r <= timeout_err_r | timeout_s;
        end
    end

    // Operand registers and result buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_r[i][j]   <= '0;
                    b_r[i][j]   <= '0;
                    res_r[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (a_we_s && (k_r == IDX_W'(i * N + j))) a_r[i][j] <= in_data;
                    if (b_we_s && (k_r == IDX_W'(i * N + j))) b_r[i][j] <= in_data;
                    if (cap_s) res_r[i][j] <= mtx_c[i][j];
                end
            end
        end
    end

    // Row-major output element select.
    always_comb begin
        out_data_s = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                out_data_s = out_data_s | ((m_r == IDX_W'(i * N + j)) ? res_r[i][j] : '0);
            end
        end
    end

    assign mtx_a       = a_r;
    assign mtx_b       = b_r;
    assign in_ready    = in_ready_r;
    assign mtx_start   = mtx_start_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_s;
    assign out_last    = out_last_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer: engine model computes c = a - b, expected
// results are queued when operands are sent and checked as the DUT drains them.
module tb_matrix_op_sequencer;

    localparam int ENG_NORMAL = 0;
    localparam int ENG_STICKY = 1;
    localparam int ENG_NEVER  = 2;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  mtx_a [0:3][0:3];
    logic [7:0]  mtx_b [0:3][0:3];
    logic        mtx_start;
    logic [15:0] eng_c [0:3][0:3] = '{default: 16'h0000};
    logic        eng_done = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        timeout_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          eng_mode = ENG_NORMAL;
    int          eng_cnt = 0;
    logic        eng_run = 1'b0;
    logic        ready_rand = 1'b0;
    logic [7:0]  op_a [16];
    logic [7:0]  op_b [16];
    exp_t        exp_q [$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0000;

    matrix_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mtx_a(mtx_a), .mtx_b(mtx_b), .mtx_start(mtx_start), .mtx_c(eng_c), .mtx_done(eng_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine model: results and done appear 21 cycles after start; sticky mode keeps the old done level.
    always @(posedge clk) begin
        if (mtx_start) begin
            eng_cnt <= 0;
            eng_run <= 1'b1;
            if (eng_mode != ENG_STICKY) eng_done <= 1'b0;
        end else if (eng_run) begin
            if (eng_cnt == 20) begin
                eng_run <= 1'b0;
                if (eng_mode != ENG_NEVER) begin
                    eng_done <= 1'b1;
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            eng_c[i][j] <= {8'h00, mtx_a[i][j]} - {8'h00, mtx_b[i][j]};
                end
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    // Output monitor: scoreboard pop, hold-while-stalled checks.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // out_ready driver: always high, or about 30% low when ready_rand is set.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    task automatic run_op(input int mode, input bit gaps, input bit finish);
        int   n;
        logic hs;
        exp_t e;
        eng_mode = mode;
        if (mode != ENG_NEVER) begin
            for (int i = 0; i < 16; i++) begin
                e.data = {8'h00, op_a[i]} - {8'h00, op_b[i]};
                e.last = (i == 15);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_data  = (i < 16) ? op_a[i] : op_b[i - 16];
            n = 0;
            do begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!hs && n < 100);
            chk("in_accept", 32'(hs), 32'd1);
        end
        in_valid = 1'b0;
        chk("start_pulse", 32'(mtx_start), 32'd1);
        chk("busy_start", 32'(busy), 32'd1);
        chk("in_ready_start", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("start_once", 32'(mtx_start), 32'd0);
        if (finish) begin
            n = 1;
            if (mode == ENG_NEVER) begin
                while (!timeout_err && n < 2000) begin @(posedge clk); #1; n++; end
                chk("timeout_cycles", 32'(n), 32'd1024);
                chk("timeout_in_ready", 32'(in_ready), 32'd1);
                chk("timeout_no_valid", 32'(out_valid), 32'd0);
                chk("timeout_busy", 32'(busy), 32'd0);
            end else begin
                while (!out_valid && n < 2000) begin @(posedge clk); #1; n++; end
                chk("result_latency", 32'(n), 32'd25);
                n = 0;
                while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); #2; n++; end
                chk("drain_done", 32'(exp_q.size()), 32'd0);
                @(posedge clk);
                #1;
                chk("post_in_ready", 32'(in_ready), 32'd1);
                chk("post_busy", 32'(busy), 32'd0);
                chk("post_valid", 32'(out_valid), 32'd0);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_start"}, 32'(mtx_start), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
        chk({tag, "_a12"}, 32'(mtx_a[1][2]), 32'd0);
        chk({tag, "_b33"}, 32'(mtx_b[3][3]), 32'd0);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic subtraction
        for (int i = 0; i < 16; i++) begin op_a[i] = 8'h05; op_b[i] = 8'h03; end
        run_op(ENG_NORMAL, 1'b0, 1'b1);

        // Sticky done: stale results (0x0002) must not be captured
        for (int i = 0; i < 16; i++) begin op_a[i] = 8'h80 + 8'(i); op_b[i] = 8'(i); end
        run_op(ENG_STICKY, 1'b0, 1'b1);

        // Ordering and wrap
        for (int i = 0; i < 16; i++) begin op_a[i] = 8'(i); op_b[i] = 8'h01; end
        run_op(ENG_NORMAL, 1'b0, 1'b1);

        // Backpressure with input gaps
        ready_rand = 1'b1;
        for (int i = 0; i < 16; i++) begin op_a[i] = 8'($urandom); op_b[i] = 8'($urandom); end
        run_op(ENG_NORMAL, 1'b1, 1'b1);
        ready_rand = 1'b0;

        // Timeout
        run_op(ENG_NEVER, 1'b0, 1'b1);

        // Reset during WAIT
        for (int i = 0; i < 16; i++) begin op_a[i] = 8'h40 + 8'(i); op_b[i] = 8'h11; end
        run_op(ENG_NORMAL, 1'b0, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        chk("wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_wait");
        exp_q.delete();
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset during DRAIN at element 7
        run_op(ENG_NORMAL, 1'b0, 1'b0);
        n = 0;
        while (exp_q.size() > 9 && n < 200) begin @(negedge clk); #2; n++; end
        @(posedge clk);
        #1;
        chk("m7_valid", 32'(out_valid), 32'd1);
        chk("m7_data", 32'(out_data), 32'({8'h00, op_a[7]} - {8'h00, op_b[7]}));
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_drain");
        exp_q.delete();
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full transaction after reset
        for (int i = 0; i < 16; i++) begin op_a[i] = 8'(i); op_b[i] = 8'h01; end
        run_op(ENG_NORMAL, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_op_sequencer.md
# matrix_op_sequencer

Initiator and stream adapter for the 4x4 matrix arithmetic engines (start/done, parallel-array style).
- Accepts 32 operand bytes over a valid/ready input stream and assembles matrices A and B.
- Pulses the engine's start, waits for qualified completion, then snapshots the 16 results.
- Drains the results as a valid/ready output stream, row-major.
- Sits between the NPU host-side byte fabric and one matrix engine instance.

## Interface
- `N`, 4, matrix dimension; element count is N*N.
- `DATA_W`, 8, operand element width.
- `RES_W`, 16, result element width.
- `GUARD_CYCLES`, 24, cycles after start during which engine done is ignored (done may still be high from the previous op).
- `TIMEOUT`, 1023, max WAIT cycles before abort.
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand byte valid.
- `in_ready`  out  1  operand byte accepted when in_valid && in_ready.
- `in_data`  in  DATA_W  operand byte; first N*N bytes are A, next N*N are B, row-major.
- `mtx_a`, `mtx_b`  out  DATA_W x [0:N-1][0:N-1]  operand arrays to engine.
- `mtx_start`  out  1  one-cycle start pulse.
- `mtx_c`  in  RES_W x [0:N-1][0:N-1]  engine result array.
- `mtx_done`  in  1  engine completion level.
- `out_valid`  out  1  result element valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  RES_W  result element, row-major.
- `out_last`  out  1  high with element N*N-1.
- `busy`  out  1  high in START/WAIT/DRAIN.
- `timeout_err`  out  1  sticky; set on WAIT timeout, cleared only by reset.

## Operation
- States: LOAD_A, LOAD_B, START, WAIT, DRAIN.
- Reset state is LOAD_A. All arrays, counters, `mtx_start`, `out_valid`, `out_last` and `timeout_err` reset to 0.
- `in_ready` = 1 in LOAD_A/LOAD_B, so it is 1 during and after reset; 0 in all other states.
- Load index k, 0..N*N-1:
  - On each accepted byte, write element [k/N][k%N] of A (LOAD_A) or B (LOAD_B), then increment k.
  - On k = N*N-1 accepted, k wraps to 0 and state advances LOAD_A->LOAD_B or LOAD_B->START.
- `mtx_a` and `mtx_b` are driven directly from the operand registers. They are stable from START through DRAIN.
- START: `mtx_start` = 1 for exactly this one cycle; clear wait counter; go to WAIT.
- WAIT: increment wait counter each cycle. Exits are evaluated in priority order:
  - **Completion:** if counter >= GUARD_CYCLES and `mtx_done` = 1, capture all of `mtx_c` into the local result buffer and go to DRAIN.
  - **Timeout:** else if counter = TIMEOUT, set `timeout_err`, discard the operation and go to LOAD_A (no output emitted).
- DRAIN, with output index m from 0:
  - `out_valid` = 1 and `out_data` = result[m/N][m%N]; `out_last` = (m = N*N-1).
  - m advances on out_valid && out_ready. `out_data` holds while stalled.
  - After the last element is accepted: m->0, state->LOAD_A.
- Results are passed through unmodified at RES_W; the sequencer does no arithmetic or width conversion.
- Input bytes offered outside LOAD states are not consumed (`in_ready` = 0).

## Timing
- `mtx_start` is asserted the cycle after the 2N*N-th byte handshake.
- Engine done is first sampled GUARD_CYCLES cycles after the start cycle.
- Result capture happens on the edge where the WAIT completion condition is true. `out_valid` is 1 the following cycle.
- With `out_ready` held high, one element per cycle: N*N cycles in DRAIN.
- LOAD_A (`in_ready` = 1) occurs the cycle after the final output handshake.
- Back-to-back bytes with `in_valid` held high load one per cycle with no bubbles.
- Reset asserted mid-operation (any state) immediately returns to LOAD_A with all outputs at reset values. The partially loaded operands and the result buffer are zeroed.
- `out_valid` never drops once asserted until its handshake, except on reset.

## Test plan
- **Basic subtraction:** reset; bench engine model computes c = a - b zero-extended to 16 bits, done at 21 cycles. Send 16x 0x05 then 16x 0x03 -> one `mtx_start` pulse, then 16 outputs of 0x0002, `out_last` on the 16th only.
- **Ordering and wrap:** A byte k = k, B all 0x01; A[0][0] = 0 gives 0 - 1. Expect outputs 0xFFFF, 0x0000, 0x0001, ..., 0x000E in row-major order.
- **Sticky done:** engine model holds done = 1 from a prior op and produces new results only at cycle 21. Expect the second op's outputs to reflect the new operands, not stale data (guard honoured).
- **Backpressure:** random `out_ready` (about 30% low) and random `in_valid` gaps -> no lost or duplicated element, and `out_data` stable while stalled.
- **Timeout:** engine never raises done -> `timeout_err` = 1 at start + TIMEOUT + 1 cycles, no `out_valid`, and `in_ready` = 1 the next cycle.
- **Reset mid-op:** assert `rst_n` low during WAIT and again during DRAIN at m = 7 -> all outputs return to reset values immediately. A subsequent full transaction produces correct results.
